// File: rtl/shadow_pkg.sv
// Shared types, constants and helper functions for the byte-serial Shadow engine.
package shadow_pkg;

   localparam int BR_W    = 8;
   localparam int KEY_ROT = 13;
   localparam int KEY_MAX = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WIND = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [BR_W-1:0] rotl8(input logic [BR_W-1:0] x, input int unsigned n);
      int unsigned s;
      s = n % BR_W;
      return (x << s) | (x >> ((BR_W - s) % BR_W));
   endfunction

   function automatic logic [BR_W-1:0] f(input logic [BR_W-1:0] x);
      return (rotl8(x, 1) & rotl8(x, 7)) ^ rotl8(x, 2);
   endfunction

   function automatic logic [KEY_MAX-1:0] key_mask(input int w);
      if (w >= KEY_MAX)
         return '1;
      return (KEY_MAX'(1) << w) - KEY_MAX'(1);
   endfunction

   // Key schedule works on a KEY_MAX container; w selects the live width.
   function automatic logic [KEY_MAX-1:0] key_fwd(input logic [KEY_MAX-1:0] k, input int w,
                                                  input logic [5:0] r);
      return (((k << KEY_ROT) | (k >> (w - KEY_ROT))) & key_mask(w))
             ^ {{(KEY_MAX-6){1'b0}}, r};
   endfunction

   function automatic logic [KEY_MAX-1:0] key_inv(input logic [KEY_MAX-1:0] k, input int w,
                                                  input logic [5:0] r);
      logic [KEY_MAX-1:0] x;
      x = k ^ {{(KEY_MAX-6){1'b0}}, r - 6'd1};
      return ((x >> KEY_ROT) | (x << (w - KEY_ROT))) & key_mask(w);
   endfunction

endpackage

// File: rtl/shadow_serial_core_branch.sv
// Combinational two-branch Feistel step, forward or inverse.
module shadow_branch
   import shadow_pkg::*;
(
   input  logic [BR_W-1:0] in0,
   input  logic [BR_W-1:0] in1,
   input  logic [BR_W-1:0] k,
   input  logic            inv,
   output logic [BR_W-1:0] out0,
   output logic [BR_W-1:0] out1
);

   assign out0 = inv ? in1 : (in1 ^ f(in0) ^ k);
   assign out1 = inv ? (in0 ^ f(in1) ^ k) : in0;

endmodule

// File: rtl/shadow_serial_core.sv
// Byte-serial Shadow block cipher: one branch step per cycle, encrypt or decrypt.
//
// state | meaning
// IDLE  | waiting for start; done may be pulsing from the previous operation
// WIND  | decrypt only: rolls the key schedule forward to the last round key
// RUN   | one branch step per cycle; round permute and key update on last step
// DONE  | result ready; publishes dout and pulses done on the way back to IDLE
module shadow_serial_core
   import shadow_pkg::*;
#(
   parameter int BLOCK_W = 32,
   parameter int KEY_W   = 2*BLOCK_W,
   parameter int ROUNDS  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   input  logic [BLOCK_W-1:0] din,
   input  logic [KEY_W-1:0]   key,
   output logic               busy,
   output logic               done,
   output logic [BLOCK_W-1:0] dout
);

   localparam int NBR   = BLOCK_W / 16;
   localparam int NSTEP = 2 * NBR;
   localparam int SW    = $clog2(NSTEP);
   localparam int PW    = $clog2(NBR);

   localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);
   localparam logic [5:0]    LAST_RND  = 6'(ROUNDS - 1);
   localparam logic [5:0]    WIND_END  = 6'(ROUNDS - 2);

   state_t               r_fsm;
   logic                 r_mode;
   logic [SW-1:0]        r_step;
   logic [5:0]           r_rnd;
   logic [BLOCK_W-1:0]   r_state;
   logic [KEY_W-1:0]     r_key;

   logic [PW-1:0]        w_pair;
   logic [BLOCK_W-1:0]   w_rk;
   logic [BR_W-1:0]      w_u;
   logic [BR_W-1:0]      w_v;
   logic [BR_W-1:0]      w_kb;
   logic [BR_W-1:0]      w_out0;
   logic [BR_W-1:0]      w_out1;
   logic [BLOCK_W-1:0]   w_state_step;
   logic [BLOCK_W-1:0]   w_state_next;
   logic                 w_last;
   logic                 w_final;
   logic [KEY_W-1:0]     w_key_fwd;
   logic [KEY_W-1:0]     w_key_inv;

   shadow_branch u_branch (
      .in0  (w_u),
      .in1  (w_v),
      .k    (w_kb),
      .inv  (r_mode),
      .out0 (w_out0),
      .out1 (w_out1)
   );

   assign w_key_fwd = KEY_W'(key_fwd(KEY_MAX'(r_key), KEY_W, r_rnd));
   assign w_key_inv = KEY_W'(key_inv(KEY_MAX'(r_key), KEY_W, r_rnd));

   // Step j works on pair (j mod NBR) with round-key byte j; decrypt walks j downwards.
   always_comb begin
      w_pair = r_step[PW-1:0];
      w_rk   = r_key[KEY_W-1 -: BLOCK_W];
      w_kb   = w_rk[BLOCK_W-1-BR_W*int'(r_step) -: BR_W];
      w_u    = r_state[BLOCK_W-1-16*int'(w_pair) -: BR_W];
      w_v    = r_state[BLOCK_W-1-BR_W-16*int'(w_pair) -: BR_W];

      w_state_step = r_state;
      w_state_step[BLOCK_W-1-16*int'(w_pair) -: BR_W]      = w_out0;
      w_state_step[BLOCK_W-1-BR_W-16*int'(w_pair) -: BR_W] = w_out1;

      w_last  = r_mode ? (r_step == '0) : (r_step == LAST_STEP);
      w_final = r_mode ? (r_rnd == 6'd0) : (r_rnd == LAST_RND);

      w_state_next = w_state_step;
      if (w_last && !w_final) begin
         if (r_mode)
            w_state_next = {w_state_step[BR_W-1:0], w_state_step[BLOCK_W-1:BR_W]};
         else
            w_state_next = {w_state_step[BLOCK_W-BR_W-1:0], w_state_step[BLOCK_W-1 -: BR_W]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm   <= IDLE;
         r_mode  <= 1'b0;
         r_step  <= '0;
         r_rnd   <= '0;
         r_state <= '0;
         r_key   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dout    <= '0;
      end else begin
         done <= 1'b0;
         case (r_fsm)
            IDLE: begin
               if (start) begin
                  r_mode  <= mode;
                  r_state <= din;
                  r_key   <= key;
                  r_rnd   <= '0;
                  busy    <= 1'b1;
                  if (mode) begin
                     r_step <= LAST_STEP;
                     r_fsm  <= WIND;
                  end else begin
                     r_step <= '0;
                     r_fsm  <= RUN;
                  end
               end
            end
            WIND: begin
               r_key <= w_key_fwd;
               if (r_rnd == WIND_END) begin
                  r_rnd <= LAST_RND;
                  r_fsm <= RUN;
               end else begin
                  r_rnd <= r_rnd + 6'd1;
               end
            end
            RUN: begin
               r_state <= w_state_next;
               r_step  <= r_mode ? (r_step - 1'b1) : (r_step + 1'b1);
               if (w_last) begin
                  r_key <= r_mode ? w_key_inv : w_key_fwd;
                  if (w_final) begin
                     busy  <= 1'b0;
                     r_fsm <= DONE;
                  end else begin
                     r_rnd <= r_mode ? (r_rnd - 6'd1) : (r_rnd + 6'd1);
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               dout  <= r_state;
               r_fsm <= IDLE;
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shadow_serial_core.sv
// Self-checking bench: 32-bit and 64-bit engines plus the branch unit against a byte-array model.
module tb_shadow_serial_core;

   localparam int N_RT32 = 20;
   localparam int N_RT64 = 48;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start32, mode32, busy32, done32;
   logic [31:0] din32, dout32;
   logic [63:0] key32;

   logic         start64, mode64, busy64, done64;
   logic [63:0]  din64, dout64;
   logic [127:0] key64;

   logic [7:0] b_in0, b_in1, b_k, b_out0, b_out1;
   logic       b_inv;

   int checks   = 0;
   int failures = 0;

   shadow_serial_core #(.BLOCK_W(32), .KEY_W(64), .ROUNDS(16)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .mode(mode32), .din(din32), .key(key32),
      .busy(busy32), .done(done32), .dout(dout32));

   shadow_serial_core #(.BLOCK_W(64), .KEY_W(128), .ROUNDS(32)) dut64 (
      .clk(clk), .rst(rst), .start(start64), .mode(mode64), .din(din64), .key(key64),
      .busy(busy64), .done(done64), .dout(dout64));

   shadow_branch ubr (
      .in0(b_in0), .in1(b_in1), .k(b_k), .inv(b_inv), .out0(b_out0), .out1(b_out1));

   // ---------------- reference model (byte arrays) ----------------
   function automatic logic [7:0] mf(input logic [7:0] x);
      logic [7:0] r1, r7, r2;
      r1 = {x[6:0], x[7]};
      r7 = {x[0], x[7:1]};
      r2 = {x[5:0], x[7:6]};
      return (r1 & r7) ^ r2;
   endfunction

   function automatic logic [127:0] mmask(input int kw);
      if (kw == 128) return '1;
      return (128'd1 << kw) - 128'd1;
   endfunction

   function automatic logic [127:0] mupd(input logic [127:0] k, input int kw, input int r);
      return (((k << 13) | (k >> (kw - 13))) & mmask(kw)) ^ 128'(r & 63);
   endfunction

   function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [127:0] key,
                                             input int bw, input int rounds);
      logic [7:0]   s [8];
      logic [127:0] k;
      logic [63:0]  rk, res;
      logic [7:0]   kb, u, v, t;
      int nb, np, kw, p;
      nb = bw / 8; np = bw / 16; kw = 2 * bw;
      for (int i = 0; i < 8; i++) s[i] = 8'h00;
      for (int i = 0; i < nb; i++) s[i] = 8'(pt >> (bw - 8 - 8*i));
      k = key & mmask(kw);
      for (int r = 0; r < rounds; r++) begin
         rk = 64'(k >> (kw - bw));
         for (int j = 0; j < 2*np; j++) begin
            p  = j % np;
            kb = 8'(rk >> (bw - 8 - 8*j));
            u = s[2*p]; v = s[2*p+1];
            s[2*p]   = v ^ mf(u) ^ kb;
            s[2*p+1] = u;
         end
         if (r != rounds - 1) begin
            t = s[0];
            for (int i = 0; i < nb - 1; i++) s[i] = s[i+1];
            s[nb-1] = t;
         end
         k = mupd(k, kw, r);
      end
      res = '0;
      for (int i = 0; i < nb; i++) res = (res << 8) | 64'(s[i]);
      return res;
   endfunction

   function automatic logic [63:0] model_dec(input logic [63:0] ct, input logic [127:0] key,
                                             input int bw, input int rounds);
      logic [7:0]   s [8];
      logic [127:0] ks [64];
      logic [63:0]  rk, res;
      logic [7:0]   kb, a, b, t;
      int nb, np, kw, p;
      nb = bw / 8; np = bw / 16; kw = 2 * bw;
      for (int i = 0; i < 8; i++) s[i] = 8'h00;
      for (int i = 0; i < nb; i++) s[i] = 8'(ct >> (bw - 8 - 8*i));
      ks[0] = key & mmask(kw);
      for (int r = 1; r < rounds; r++) ks[r] = mupd(ks[r-1], kw, r - 1);
      for (int r = rounds - 1; r >= 0; r--) begin
         rk = 64'(ks[r] >> (kw - bw));
         for (int j = 2*np - 1; j >= 0; j--) begin
            p  = j % np;
            kb = 8'(rk >> (bw - 8 - 8*j));
            a = s[2*p]; b = s[2*p+1];
            s[2*p]   = b;
            s[2*p+1] = a ^ mf(b) ^ kb;
         end
         if (r != 0) begin
            t = s[nb-1];
            for (int i = nb - 1; i > 0; i--) s[i] = s[i-1];
            s[0] = t;
         end
      end
      res = '0;
      for (int i = 0; i < nb; i++) res = (res << 8) | 64'(s[i]);
      return res;
   endfunction

   // ---------------- stimulus drivers ----------------
   task automatic run32(input logic m, input logic [31:0] d, input logic [63:0] k,
                        output logic [31:0] q, output int lat);
      mode32 = m; din32 = d; key32 = k; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      lat = -1; q = '0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         if (done32) begin lat = c; q = dout32; break; end
      end
   endtask

   task automatic run64(input logic m, input logic [63:0] d, input logic [127:0] k,
                        output logic [63:0] q, output int lat);
      mode64 = m; din64 = d; key64 = k; start64 = 1'b1;
      @(posedge clk); #1;
      start64 = 1'b0;
      lat = -1; q = '0;
      for (int c = 1; c <= 1000; c++) begin
         @(posedge clk); #1;
         if (done64) begin lat = c; q = dout64; break; end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy32 got=%b exp=0", busy32); end
      checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL reset_done32 got=%b exp=0", done32); end
      checks++; if (dout32 !== 32'h0) begin failures++; $display("FAIL reset_dout32 got=%h exp=0", dout32); end
      checks++; if (busy64 !== 1'b0) begin failures++; $display("FAIL reset_busy64 got=%b exp=0", busy64); end
      checks++; if (done64 !== 1'b0) begin failures++; $display("FAIL reset_done64 got=%b exp=0", done64); end
      checks++; if (dout64 !== 64'h0) begin failures++; $display("FAIL reset_dout64 got=%h exp=0", dout64); end
   endtask

   task automatic test_branch();
      logic [7:0] e0, e1, f0, f1;
      b_in0 = 8'h01; b_in1 = 8'h00; b_k = 8'h00; b_inv = 1'b0; #1;
      checks++; if (b_out0 !== 8'h04) begin failures++; $display("FAIL branch_fwd_out0 got=%h exp=04", b_out0); end
      checks++; if (b_out1 !== 8'h01) begin failures++; $display("FAIL branch_fwd_out1 got=%h exp=01", b_out1); end
      b_in0 = 8'h04; b_in1 = 8'h01; b_inv = 1'b1; #1;
      checks++; if (b_out0 !== 8'h01) begin failures++; $display("FAIL branch_inv_out0 got=%h exp=01", b_out0); end
      checks++; if (b_out1 !== 8'h00) begin failures++; $display("FAIL branch_inv_out1 got=%h exp=00", b_out1); end
      for (int i = 0; i < 8; i++) begin
         b_in0 = 8'($urandom); b_in1 = 8'($urandom); b_k = 8'($urandom); b_inv = 1'b0;
         e0 = b_in1 ^ mf(b_in0) ^ b_k; e1 = b_in0; #1;
         checks++; if ({b_out0, b_out1} !== {e0, e1}) begin
            failures++; $display("FAIL branch_rand_fwd got=%h exp=%h", {b_out0, b_out1}, {e0, e1}); end
         f0 = b_in0; f1 = b_in1;
         b_in0 = e0; b_in1 = e1; b_inv = 1'b1; #1;
         checks++; if ({b_out0, b_out1} !== {f0, f1}) begin
            failures++; $display("FAIL branch_rand_inv got=%h exp=%h", {b_out0, b_out1}, {f0, f1}); end
      end
   endtask

   task automatic test_roundtrip32();
      logic [31:0] ct, pt, exp_ct;
      int lat;
      @(posedge clk); #1;
      exp_ct = 32'(model_enc(64'h01234567, 128'h0011223344556677, 32, 16));
      run32(1'b0, 32'h01234567, 64'h0011223344556677, ct, lat);
      checks++; if (lat !== 65) begin failures++; $display("FAIL enc32_latency got=%0d exp=65", lat); end
      checks++; if (ct !== exp_ct) begin failures++; $display("FAIL enc32_result got=%h exp=%h", ct, exp_ct); end
      run32(1'b1, ct, 64'h0011223344556677, pt, lat);
      checks++; if (lat !== 80) begin failures++; $display("FAIL dec32_latency got=%0d exp=80", lat); end
      checks++; if (pt !== 32'h01234567) begin failures++; $display("FAIL dec32_result got=%h exp=01234567", pt); end
   endtask

   task automatic test_ignore_start();
      logic [31:0] pt, exp_ct, cap;
      logic [63:0] k;
      int n_done, lat;
      @(posedge clk); #1;
      pt = $urandom; k = {$urandom, $urandom};
      exp_ct = 32'(model_enc(64'(pt), 128'(k), 32, 16));
      mode32 = 1'b0; din32 = pt; key32 = k; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      n_done = 0; lat = -1; cap = '0;
      for (int c = 1; c <= 150; c++) begin
         @(posedge clk); #1;
         if (done32) begin n_done++; lat = c; cap = dout32; end
         // pulses land on edges 5, 40 (RUN) and 65 (DONE)
         start32 = (c == 4 || c == 39 || c == 64);
         mode32 = 1'b1; din32 = $urandom; key32 = {$urandom, $urandom};
      end
      start32 = 1'b0;
      checks++; if (n_done !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
      checks++; if (lat !== 65) begin failures++; $display("FAIL ignore_latency got=%0d exp=65", lat); end
      checks++; if (cap !== exp_ct) begin failures++; $display("FAIL ignore_result got=%h exp=%h", cap, exp_ct); end
      checks++; if (dout32 !== exp_ct) begin failures++; $display("FAIL ignore_dout_hold got=%h exp=%h", dout32, exp_ct); end
      checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL ignore_busy_end got=%b exp=0", busy32); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] pt, exp_ct, ct;
      logic [63:0] k;
      int lat;
      @(posedge clk); #1;
      pt = $urandom; k = {$urandom, $urandom};
      exp_ct = 32'(model_enc(64'(pt), 128'(k), 32, 16));
      mode32 = 1'b0; din32 = pt; key32 = k; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL midrun_busy got=%b exp=1", busy32); end
      rst = 1'b1; #1;
      checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy32); end
      checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done32); end
      checks++; if (dout32 !== 32'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0", dout32); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run32(1'b0, pt, k, ct, lat);
      checks++; if (lat !== 65) begin failures++; $display("FAIL rst_restart_latency got=%0d exp=65", lat); end
      checks++; if (ct !== exp_ct) begin failures++; $display("FAIL rst_restart_result got=%h exp=%h", ct, exp_ct); end
   endtask

   task automatic test_rand32();
      logic [31:0] d, q, e;
      logic [63:0] k;
      logic        m;
      int lat, el;
      for (int i = 0; i < N_RT32; i++) begin
         d = $urandom; k = {$urandom, $urandom}; m = 1'($urandom);
         e  = m ? 32'(model_dec(64'(d), 128'(k), 32, 16)) : 32'(model_enc(64'(d), 128'(k), 32, 16));
         el = m ? 80 : 65;
         run32(m, d, k, q, lat);
         checks++; if (lat !== el) begin failures++; $display("FAIL rand32_latency i=%0d mode=%b got=%0d exp=%0d", i, m, lat, el); end
         checks++; if (q !== e) begin failures++; $display("FAIL rand32_result i=%0d mode=%b got=%h exp=%h", i, m, q, e); end
      end
   endtask

   task automatic test_rand64();
      logic [63:0]  pt, ct, rt, e;
      logic [127:0] k;
      int lat;
      for (int i = 0; i < N_RT64; i++) begin
         pt = {$urandom, $urandom};
         k  = {$urandom, $urandom, $urandom, $urandom};
         e  = model_enc(pt, k, 64, 32);
         run64(1'b0, pt, k, ct, lat);
         checks++; if (lat !== 257) begin failures++; $display("FAIL enc64_latency i=%0d got=%0d exp=257", i, lat); end
         checks++; if (ct !== e) begin failures++; $display("FAIL enc64_result i=%0d got=%h exp=%h", i, ct, e); end
         run64(1'b1, ct, k, rt, lat);
         checks++; if (lat !== 288) begin failures++; $display("FAIL dec64_latency i=%0d got=%0d exp=288", i, lat); end
         checks++; if (rt !== pt) begin failures++; $display("FAIL dec64_roundtrip i=%0d got=%h exp=%h", i, rt, pt); end
      end
   endtask

   initial begin
      start32 = 1'b0; mode32 = 1'b0; din32 = '0; key32 = '0;
      start64 = 1'b0; mode64 = 1'b0; din64 = '0; key64 = '0;
      b_in0 = '0; b_in1 = '0; b_k = '0; b_inv = 1'b0;
      test_reset();
      test_branch();
      test_roundtrip32();
      test_ignore_start();
      test_reset_mid();
      test_rand32();
      test_rand64();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
